// File: rtl/sd_cmd_sequencer.sv
// SD command-line sequencer: generates SD_CLK, sends power-up clocks, then
// serialises one 48-bit command frame (with CRC7) per accepted request.
module sd_cmd_sequencer #(
  parameter int unsigned CLK_DIV    = 30,
  parameter int unsigned INIT_CLKS  = 80,
  parameter int unsigned TRAIL_CLKS = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [5:0]  CMD_INDEX,
  input  logic [31:0] CMD_ARG,
  output logic        SD_CLK,
  output logic        SD_CMD,
  output logic        BUSY,
  output logic        DONE,
  output logic [6:0]  CRC_OUT
);

  localparam int unsigned DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_MAX   = (INIT_CLKS > TRAIL_CLKS) ? INIT_CLKS : TRAIL_CLKS;
  localparam int unsigned CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  localparam int unsigned INIT_LAST = (INIT_CLKS > 0) ? INIT_CLKS - 1 : 0;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] INIT_END  = CW'(INIT_LAST);
  localparam logic [CW-1:0] TRAIL_END = CW'(TRAIL_CLKS);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_SEND,
    ST_TRAIL
  } state_t;

  state_t          state;
  logic [DW-1:0]   div_cnt;
  logic [5:0]      bit_cnt;
  logic [CW-1:0]   clk_cnt;
  logic [47:0]     shreg;
  logic [6:0]      crc;
  logic            sd_clk;
  logic            sd_cmd;
  logic            cmd_ready;
  logic            busy;
  logic            done;
  logic [6:0]      crc_out;

  logic            div_wrap_c;
  logic [6:0]      crc_step_c;

  // Half-period boundary of SD_CLK
  assign div_wrap_c = (div_cnt == DIV_LAST);

  // One CRC7 step folding in the bit that is being driven now
  assign crc_step_c = {crc[5:0], 1'b0} ^ (((crc[6] ^ shreg[47]) != 1'b0) ? 7'h09 : 7'h00);

  always_ff @(posedge CLK) begin
    if (RST) begin
      if (INIT_CLKS > 0) begin
        state <= ST_INIT;
        busy  <= 1'b1;
      end else begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end
      sd_clk    <= 1'b1;
      sd_cmd    <= 1'b1;
      cmd_ready <= 1'b0;
      done      <= 1'b0;
      crc_out   <= '0;
      shreg     <= '0;
      crc       <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      clk_cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (state != ST_IDLE) begin
        div_cnt <= div_wrap_c ? '0 : div_cnt + DW'(1);
      end

      unique case (state)
        // Power-up clocks; leave on the last rising edge so SD_CLK stays high
        ST_INIT: begin
          if (div_wrap_c) begin
            if (sd_clk) begin
              sd_clk <= 1'b0;
            end else begin
              sd_clk  <= 1'b1;
              clk_cnt <= clk_cnt + CW'(1);
              if (clk_cnt == INIT_END) begin
                state     <= ST_IDLE;
                busy      <= 1'b0;
                cmd_ready <= 1'b1;
                clk_cnt   <= '0;
              end
            end
          end
        end

        // Preloading the divider makes the edge after accept a falling edge
        ST_IDLE: begin
          if (CMD_VALID && cmd_ready) begin
            state     <= ST_SEND;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            shreg     <= {2'b01, CMD_INDEX, CMD_ARG, 7'b0, 1'b1};
            crc       <= '0;
            bit_cnt   <= '0;
            div_cnt   <= DIV_LAST;
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        ST_SEND: begin
          if (div_wrap_c) begin
            if (!sd_clk) begin
              sd_clk <= 1'b1;
            end else if (bit_cnt == 6'd48) begin
              if (TRAIL_CLKS == 0) begin
                state     <= ST_IDLE;
                done      <= 1'b1;
                cmd_ready <= 1'b1;
                busy      <= 1'b0;
              end else begin
                sd_clk  <= 1'b0;
                state   <= ST_TRAIL;
                clk_cnt <= '0;
              end
            end else begin
              sd_clk  <= 1'b0;
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_cnt < 6'd40) begin
                sd_cmd <= shreg[47];
                shreg  <= {shreg[46:0], 1'b0};
                crc    <= crc_step_c;
              end else if (bit_cnt < 6'd47) begin
                sd_cmd <= crc[6];
                crc    <= {crc[5:0], 1'b0};
                if (bit_cnt == 6'd40) begin
                  crc_out <= crc;
                end
              end else begin
                sd_cmd <= 1'b1;
              end
            end
          end
        end

        // Trailing clocks; finish at the end of the last high phase
        ST_TRAIL: begin
          if (div_wrap_c) begin
            if (!sd_clk) begin
              sd_clk  <= 1'b1;
              clk_cnt <= clk_cnt + CW'(1);
            end else if (clk_cnt == TRAIL_END) begin
              state     <= ST_IDLE;
              done      <= 1'b1;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              clk_cnt   <= '0;
            end else begin
              sd_clk <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign SD_CLK    = sd_clk;
  assign SD_CMD    = sd_cmd;
  assign CMD_READY = cmd_ready;
  assign BUSY      = busy;
  assign DONE      = done;
  assign CRC_OUT   = crc_out;

endmodule

// File: doc/sd_cmd_sequencer.md
Name: sd_cmd_sequencer

Overview:
- Builds and transmits one 48-bit SD command frame per request on the SD CMD line, and generates SD_CLK.
- Computes CRC7 (generator x^7 + x^3 + 1) bit-serially while the frame's first 40 bits are shifted out, then appends the CRC and the end bit.
- Sends the card power-up clocks after reset.
- Sits between the card-init FSM in microsd (requester) and the card pins.

Parameters:
- CLK_DIV, 30, CLK cycles per SD_CLK half-period (min 1); SD_CLK period = 2*CLK_DIV CLK cycles.
- INIT_CLKS, 80, number of SD_CLK cycles sent with SD_CMD high after reset (0 = skip).
- TRAIL_CLKS, 8, number of SD_CLK cycles sent with SD_CMD high after each frame's end bit.

Ports:
- CLK  in  1  system clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  request strobe.
- CMD_READY  out  1  high only in IDLE; a frame is accepted on a cycle where CMD_VALID && CMD_READY.
- CMD_INDEX  in  6  command index; sampled on accept.
- CMD_ARG  in  32  command argument; sampled on accept.
- SD_CLK  out  1  card clock; idles high.
- SD_CMD  out  1  card command line; idles high.
- BUSY  out  1  high in INIT, SEND and TRAIL.
- DONE  out  1  one-cycle pulse when TRAIL completes.
- CRC_OUT  out  7  CRC7 of the last frame; held until the next frame's CRC bits go out.

Behaviour:
- Reset values: SD_CLK=1, SD_CMD=1, CMD_READY=0, BUSY=1 (0 if INIT_CLKS=0), DONE=0, CRC_OUT=0.
- Reset state: INIT (IDLE if INIT_CLKS=0). Shift register, CRC register, divider counter and bit counter are all cleared.
- Reset applies in any state and aborts a frame mid-flight. SD_CMD returns high in the same edge. INIT re-runs.
- SD_CLK generation:
  - Active only in INIT, SEND and TRAIL.
  - Divider counter counts 0..CLK_DIV-1. SD_CLK toggles when the counter wraps.
  - SD_CMD changes only on the CLK edge where SD_CLK falls. The card samples on the SD_CLK rising edge, CLK_DIV cycles later.
- INIT:
  - INIT_CLKS full SD_CLK periods with SD_CMD=1.
  - CMD_VALID is ignored (CMD_READY=0).
  - Goes to IDLE with SD_CLK high.
- IDLE: SD_CLK=1, SD_CMD=1, CMD_READY=1, BUSY=0.
- Accept at edge T:
  - Load frame = {1'b0, 1'b1, CMD_INDEX, CMD_ARG, 7'b0, 1'b1}; clear CRC to 0.
  - Go to SEND. CMD_READY=0 and BUSY=1 from T+1.
- SEND:
  - Bit k (k=0..47, MSB first) is driven with SD_CLK low at edge T+1+2*CLK_DIV*k.
  - SD_CLK rises at T+1+2*CLK_DIV*k+CLK_DIV.
  - For k<40, on the edge that drives bit b: fb = crc[6]^b; crc <= {crc[5:0],1'b0} ^ (fb ? 7'h09 : 7'h00).
  - For k=40..46, SD_CMD drives crc[6]..crc[0]. CRC_OUT updates to the final CRC on the edge that drives bit 40.
  - Bit 47 drives 1. After its SD_CLK high phase ends, go to TRAIL.
- TRAIL:
  - TRAIL_CLKS SD_CLK periods with SD_CMD=1.
  - On the final SD_CLK rising-phase end: SD_CLK=1, DONE=1 for one cycle, state=IDLE, CMD_READY=1 in that same cycle.
  - A new CMD_VALID is accepted no earlier than the cycle after DONE.
- CMD_INDEX and CMD_ARG may change after accept with no effect on the frame.
- CMD_VALID held high continuously produces back-to-back frames, each separated by TRAIL.
- Bit counter is 6 bits, no wrap-around inside a frame. Divider counter is sized by $clog2(CLK_DIV).

Test Plan:
- Reset release, INIT_CLKS=80, CLK_DIV=2 -> exactly 80 SD_CLK rising edges with SD_CMD=1; CMD_READY rises 320 cycles after reset deassert; CMD_VALID during INIT is never accepted.
- CMD0: INDEX=0, ARG=0 -> SD_CMD sampled on SD_CLK rising edges = 0x40_00_00_00_00_95; CRC_OUT=7'h4A; DONE after 48+8 SD_CLK periods.
- CMD8: INDEX=8, ARG=0x000001AA -> frame 0x48_00_00_01_AA_87; CRC_OUT=7'h43.
- CMD55: ARG=0 then ACMD41 (INDEX=41, ARG=0x40000000) back-to-back with CMD_VALID held high -> frames 0x77_00_00_00_00_65 then 0x69_40_00_00_00_77; exactly TRAIL_CLKS idle clocks between them.
- RST asserted at bit 20 of CMD17 -> next edge: SD_CMD=1, SD_CLK=1, BUSY=1, INIT re-runs; a following CMD17 with ARG=0 yields frame 0x51_00_00_00_00_55.
- CLK_DIV=1, INIT_CLKS=0 -> CMD_READY=1 right after reset; each SD_CMD change coincides with an SD_CLK falling edge; CMD0 frame still correct.
